// File: rtl/dec_scan_seq_if.sv
// Control/status bundle between a scan controller and dec_scan_seq.
// The master side issues start/stop/config; the slave side drives the decoder enable/select.
interface dec_scan_seq_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               loop;
    logic [DWELL_W-1:0] dwell;
    logic [5:0]         mask;
    logic               en;
    logic [2:0]         a;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, loop, dwell, mask,
        input  en, a, busy, done
    );

    modport slave (
        input  start, stop, loop, dwell, mask,
        output en, a, busy, done
    );
endinterface

// File: rtl/dec_scan_seq.sv
// Scan sequencer for a 3-to-6 decoder: steps en/a through the unmasked channels with a fixed dwell.
// Optional macro DEC_SCAN_BLANK_EN inserts a one-cycle blank (en=0) between channels.
module dec_scan_seq #(
    parameter int DWELL_W = 8,
    parameter int NUM_CH  = 6
) (
    input  logic          clk,
    input  logic          rst,
    dec_scan_seq_if.slave bus
);
`ifdef DEC_SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif

    state_t              state, state_n;
    logic [DWELL_W-1:0]  cnt, cnt_n;
    logic [DWELL_W-1:0]  reload, reload_n;
    logic [NUM_CH-1:0]   mask_q, mask_n;
    logic                loop_q, loop_n;
    logic                en_q, en_n;
    logic [2:0]          a_q, a_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;

    logic [2:0]          first_in_idx, first_q_idx, next_idx;
    logic                first_in_ok, next_ok;

    // Lowest unmasked channel for both the incoming mask and the latched one,
    // plus the next unmasked channel above the one currently selected.
    always_comb begin
        first_in_idx = 3'd0;
        first_in_ok  = 1'b0;
        first_q_idx  = 3'd0;
        next_idx     = 3'd0;
        next_ok      = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!bus.mask[i]) begin
                first_in_idx = 3'(i);
                first_in_ok  = 1'b1;
            end
            if (!mask_q[i]) begin
                first_q_idx = 3'(i);
            end
            if (!mask_q[i] && (i > int'(a_q))) begin
                next_idx = 3'(i);
                next_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        reload_n = reload;
        mask_n   = mask_q;
        loop_n   = loop_q;
        en_n     = en_q;
        a_n      = a_q;
        busy_n   = busy_q;
        done_n   = 1'b0;

        if (bus.stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            en_n    = 1'b0;
            a_n     = 3'd0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en_n   = 1'b0;
                    a_n    = 3'd0;
                    busy_n = 1'b0;
                    if (bus.start) begin
                        // A zero dwell is promoted to one cycle, so the reload is dwell-1 floored at 0.
                        reload_n = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
                        mask_n   = bus.mask;
                        loop_n   = bus.loop;
                        if (first_in_ok) begin
                            state_n = DWELL;
                            cnt_n   = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
                            en_n    = 1'b1;
                            a_n     = first_in_idx;
                            busy_n  = 1'b1;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
                end

                DWELL: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_W'(1);
                    end else if (next_ok || loop_q) begin
`ifdef DEC_SCAN_BLANK_EN
                        state_n = BLANK;
                        en_n    = 1'b0;
                        done_n  = !next_ok;
`else
                        a_n    = next_ok ? next_idx : first_q_idx;
                        cnt_n  = reload;
                        done_n = !next_ok;
`endif
                    end else begin
                        state_n = IDLE;
                        en_n    = 1'b0;
                        a_n     = 3'd0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end

`ifdef DEC_SCAN_BLANK_EN
                BLANK: begin
                    state_n = DWELL;
                    en_n    = 1'b1;
                    a_n     = next_ok ? next_idx : first_q_idx;
                    cnt_n   = reload;
                end
`endif

                default: begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    a_n     = 3'd0;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            reload <= '0;
            mask_q <= '0;
            loop_q <= 1'b0;
            en_q   <= 1'b0;
            a_q    <= 3'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            reload <= reload_n;
            mask_q <= mask_n;
            loop_q <= loop_n;
            en_q   <= en_n;
            a_q    <= a_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign bus.en   = en_q;
    assign bus.a    = a_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq; expected {en,a,busy,done} values are hand-derived per step.
// Sweep-timing checks switch to the blank-cycle pattern when DEC_SCAN_BLANK_EN is defined.
module tb_dec_scan_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dec_scan_seq_if #(.DWELL_W(8)) bus ();

    dec_scan_seq #(.DWELL_W(8), .NUM_CH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic lp,
                                 input logic [7:0] dw, input logic [5:0] mk);
        bus.start = st;
        bus.stop  = sp;
        bus.loop  = lp;
        bus.dwell = dw;
        bus.mask  = mk;
    endtask

    task automatic checkOutput(input string tag, input logic e_en, input logic [2:0] e_a,
                               input logic e_busy, input logic e_done);
        logic [5:0] obs;
        logic [5:0] expv;
        obs  = {bus.en, bus.a, bus.busy, bus.done};
        expv = {e_en, e_a, e_busy, e_done};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed {en,a,busy,done}=%b expected=%b", tag, obs, expv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // Reset asserted mid-scan must clear everything.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 6'b000000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 6'b000000);
        checkOutput("scan_started", 1'b1, 3'd0, 1'b1, 1'b0);
        repeat (4) tick();
        checkOutput("scan_ch1", 1'b1, 3'd1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("midscan_reset", 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("after_reset_idle", 1'b0, 3'd0, 1'b0, 1'b0);

`ifdef DEC_SCAN_BLANK_EN
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 6'b000000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 6'b000000);
        for (int k = 0; k < 11; k++) begin
            checkOutput($sformatf("blank_sweep_%0d", k), (k % 2) == 0, 3'(k / 2), 1'b1, 1'b0);
            tick();
        end
        checkOutput("blank_sweep_done", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        checkOutput("blank_sweep_idle", 1'b0, 3'd0, 1'b0, 1'b0);
`else
        // Single sweep, dwell=2: each channel held two cycles, then done in IDLE.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, 6'b000000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd2, 6'b000000);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("single_%0d", k), 1'b1, 3'(k / 2), 1'b1, 1'b0);
            tick();
        end
        checkOutput("single_done", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        checkOutput("single_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // Masked continuous loop over channels 0,2,4 with done on each wrap.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd1, 6'b101010);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 6'b101010);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("masked_loop_%0d", k), 1'b1, 3'(2 * (k % 3)), 1'b1,
                        (k > 0) && ((k % 3) == 0));
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd1, 6'b101010);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 6'b101010);
        checkOutput("masked_loop_stop", 1'b0, 3'd0, 1'b0, 1'b0);

        // dwell=0 acts as one cycle; later config changes and a restart are ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 6'b000000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 6'b111110);
        for (int k = 0; k < 6; k++) begin
            bus.start = (k == 2);
            checkOutput($sformatf("dwell0_%0d", k), 1'b1, 3'(k), 1'b1, 1'b0);
            tick();
        end
        bus.start = 1'b0;
        checkOutput("dwell0_done", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        checkOutput("dwell0_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // stop during channel 3 of a looping scan, dwell=4.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd4, 6'b000000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd4, 6'b000000);
        repeat (13) tick();
        checkOutput("stop_in_ch3", 1'b1, 3'd3, 1'b1, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checkOutput("stop_idle", 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("stop_no_done", 1'b0, 3'd0, 1'b0, 1'b0);
`endif

        // All channels masked: no scan, done one cycle after start.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 6'b111111);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 6'b111111);
        checkOutput("allmask_done", 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        checkOutput("allmask_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        // stop together with start in IDLE starts nothing.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 6'b000000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd2, 6'b000000);
        checkOutput("stop_start_idle", 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        checkOutput("stop_start_still_idle", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
